fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. Owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction and its PC into the IF/ID pipeline register. Takes stall and flush from the hazard unit, redirects from the branch/jump resolution in EX, and halt/resume requests from the debug/control logic.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 67 ++++++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int DataBusBits  = 32;
  localparam int InstrBusBits = 32;

  // addi x0,x0,0 -- the canonical bubble written into IF/ID
  localparam logic [InstrBusBits-1:0] NopInstr = 32'h0000_0013;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats bubble, else capture.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [InstrBusBits-1:0] NOP_INSTR = NopInstr
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic                    bubble_i,
  input  logic [InstrBusBits-1:0] instr_i,
  input  logic [DataBusBits-1:0]  pc_i,
  output logic [InstrBusBits-1:0] instr_o,
  output logic [DataBusBits-1:0]  pc_o,
  output logic                    valid_o,
  output logic                    capture_o
);

  logic [InstrBusBits-1:0] instr_q, instr_d;
  logic [DataBusBits-1:0]  pc_q, pc_d;
  logic                    valid_q, valid_d;

  // Next-state selection for the pipeline register fields.
  always_comb begin
    // NOTE: every field gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    instr_d   = instr_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    capture_o = 1'b0;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      valid_d   = 1'b1;
      capture_o = 1'b1;
    end
  end

  // Register the IF/ID fields; reset leaves a bubble at PC 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALTED FSM, fetch counter, IF/ID register.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add misalign_exc, which
// traps redirects to non-word-aligned targets and bubbles IF/ID until cleared.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [DataBusBits-1:0]  RESET_PC  = '0,
  parameter logic [InstrBusBits-1:0] NOP_INSTR = NopInstr
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect,
  input  logic [DataBusBits-1:0]  redirect_pc,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [DataBusBits-1:0]  imem_addr,
  input  logic [InstrBusBits-1:0] imem_instr,
  output logic [InstrBusBits-1:0] if_id_instr,
  output logic [DataBusBits-1:0]  if_id_pc,
  output logic                    if_id_valid,
  output logic                    halted,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                    misalign_exc,
`endif
  output logic [31:0]             fetch_count
);

  fetch_state_e           state_q, state_d;
  logic [DataBusBits-1:0] pc_q, pc_d;
  logic [31:0]            fetch_count_q, fetch_count_d;
  logic                   fetch_hold;
  logic                   capture;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // An aligned redirect clears the trap, a misaligned one sets it.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  // Trap flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_exc = misalign_q;
  // Halting, a same-cycle halt request, or a pending trap freezes fetch.
  assign fetch_hold = (state_q == ST_HALTED) || halt_req || misalign_q;
`else
  // Halting or a same-cycle halt request freezes fetch.
  assign fetch_hold = (state_q == ST_HALTED) || halt_req;
`endif

  // RUN/HALTED transitions; stall masks a halt request, halt beats resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req && !stall) state_d = ST_HALTED;
      ST_HALTED: if (resume)             state_d = ST_RUN;
      default:                           state_d = ST_RUN;
    endcase
  end

  // PC next value: redirect, then stall, then halt, else sequential.
  always_comb begin
    pc_d = pc_q;
    if (redirect)                   pc_d = redirect_pc;
    else if (!stall && !fetch_hold) pc_d = pc_q + DataBusBits'(4);
  end

  // Count every valid instruction written into IF/ID; wraps naturally.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture) fetch_count_d = fetch_count_q + 32'd1;
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush | redirect),
    .stall_i   (stall),
    .bubble_i  (fetch_hold),
    .instr_i   (imem_instr),
    .pc_i      (pc_q),
    .instr_o   (if_id_instr),
    .pc_o      (if_id_pc),
    .valid_o   (if_id_valid),
    .capture_o (capture)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = fetch_count_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect, halt_req, resume;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] if_id_instr, if_id_pc;
  logic        if_id_valid, halted;
  logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_exc;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halted, m_mis;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_exc(misalign_exc),
`endif
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a word-indexed hash, low address bits ignored.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
    m_halted = 1'b0; m_count = 32'h0; m_mis = 1'b0;
  endtask

  // One clock edge of the fetch rules, using the inputs currently driven.
  task automatic model_step();
    logic        frozen;
    logic [31:0] pc_old;
    pc_old = m_pc;
    frozen = m_halted || halt_req;
`ifdef FETCH_MISALIGN_CHECK_EN
    frozen = frozen || m_mis;
    if (redirect) m_mis = (redirect_pc[1:0] != 2'b00);
`endif
    if (redirect)     m_pc = redirect_pc;
    else if (stall)   m_pc = pc_old;
    else if (frozen)  m_pc = pc_old;
    else              m_pc = pc_old + 32'd4;

    if (flush || redirect) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (stall) begin
      // IF/ID keeps its contents
    end else if (frozen) begin
      m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(pc_old); m_ipc = pc_old; m_valid = 1'b1;
      m_count = m_count + 32'd1;
    end

    if (!m_halted) m_halted = halt_req && !stall;
    else           m_halted = !resume;
  endtask

  task automatic check_all();
    check_eq("imem_addr",   imem_addr,          m_pc);
    check_eq("if_id_instr", if_id_instr,        m_instr);
    check_eq("if_id_pc",    if_id_pc,           m_ipc);
    check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check_eq("halted",      {31'b0, halted},    {31'b0, m_halted});
    check_eq("fetch_count", fetch_count,        m_count);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("misalign_exc", {31'b0, misalign_exc}, {31'b0, m_mis});
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic cyc(input logic st, input logic fl, input logic rd,
                     input logic [31:0] rpc, input logic hr, input logic rs);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    halt_req = hr; resume = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Reset asserted mid-cycle must take effect without a clock edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; flush = 0; redirect = 0; redirect_pc = 0; halt_req = 0; resume = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch from reset.
    idle(4);
    check_eq("plan_addr16", imem_addr, 32'd16);
    check_eq("plan_count4", fetch_count, 32'd4);
    check_eq("plan_ipc12",  if_id_pc, 32'd12);

    // Stall two cycles, then release.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("plan_stall_count", fetch_count, 32'd4);
    idle(2);

    // Redirect together with stall: redirect wins, bubble inserted.
    cyc(1, 0, 1, 32'h100, 0, 0);
    check_eq("plan_redir_addr", imem_addr, 32'h100);
    check_eq("plan_redir_valid", {31'b0, if_id_valid}, 32'd0);
    idle(1);
    check_eq("plan_redir_ipc", if_id_pc, 32'h100);

    // Halt for one cycle, three idle cycles, then resume.
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("plan_halt_off", {31'b0, halted}, 32'd0);
    idle(2);

    // Halt and resume together while running: halt wins.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 32'h300, 0, 0);   // redirect while halted stays halted
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // Counter wrap.
    @(negedge clk);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_count = 32'hFFFF_FFFF;
    idle(1);
    check_eq("plan_wrap", fetch_count, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    cyc(0, 0, 1, 32'h102, 0, 0);
    idle(3);
    check_eq("plan_mis_set", {31'b0, misalign_exc}, 32'd1);
    cyc(0, 0, 1, 32'h200, 0, 0);
    idle(2);
    check_eq("plan_mis_ipc", if_id_pc, 32'h204);
`endif

    // Random traffic against the model, with one mid-run async reset.
    for (int i = 0; i < 400; i++) begin
      logic        st, fl, rd, hr, rs;
      logic [31:0] rpc;
      if (i == 200) async_reset();
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 11) == 0);
      rs  = ($urandom_range(0, 2) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc(st, fl, rd, rpc, hr, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_fetch_stage
